// File: rtl/dmem_port_arbiter.sv
// Shares one single-ported data memory between the two pipeline lanes' EX/MEM
// requests. Requests are served oldest lane first, and the pipeline is stalled
// until the whole batch has completed.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MEM_LAT = 1   // legal range 1..15
) (
  input  logic              clk,
  input  logic              reset,      // asynchronous, active low
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req2_valid,
  input  logic              req2_we,
  input  logic [ADDR_W-1:0] req2_addr,
  input  logic [DATA_W-1:0] req2_wdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              rvalid1,
  output logic              rvalid2,
  output logic              stall
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  logic [1:0]        state_q, state_d;
  logic              pend1_q, pend1_d, pend2_q, pend2_d;
  logic              v1_q, v1_d, we1_q, we1_d;
  logic              v2_q, v2_d, we2_q, we2_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
  logic [DATA_W-1:0] wdata1_q, wdata1_d, wdata2_q, wdata2_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d;

  // Lane 1 stays selected until its pend bit drops, which gives program order.
  logic              sel2;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              more;

  assign sel2      = ~pend1_q;
  assign sel_we    = sel2 ? we2_q : we1_q;
  assign sel_addr  = sel2 ? addr2_q : addr1_q;
  assign sel_wdata = sel2 ? wdata2_q : wdata1_q;
  // Only lane 1 can leave work behind: when lane 2 is selected lane 1 is done.
  assign more      = ~sel2 & pend2_q;

  // Next-state and batch bookkeeping.
  always_comb begin
    state_d  = state_q;
    pend1_d  = pend1_q;
    pend2_d  = pend2_q;
    v1_d     = v1_q;
    we1_d    = we1_q;
    addr1_d  = addr1_q;
    wdata1_d = wdata1_q;
    v2_d     = v2_q;
    we2_d    = we2_q;
    addr2_d  = addr2_q;
    wdata2_d = wdata2_q;
    cnt_d    = cnt_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    case (state_q)
      IDLE: begin
        if (req1_valid || req2_valid) begin
          v1_d     = req1_valid;
          we1_d    = req1_we;
          addr1_d  = req1_addr;
          wdata1_d = req1_wdata;
          v2_d     = req2_valid;
          we2_d    = req2_we;
          addr2_d  = req2_addr;
          wdata2_d = req2_wdata;
          pend1_d  = req1_valid;
          pend2_d  = req2_valid;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (sel_we) begin
          if (sel2) pend2_d = 1'b0;
          else      pend1_d = 1'b0;
          state_d = more ? ISSUE : RESP;
        end else begin
          cnt_d   = LAT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (sel2) begin
            rdata2_d = mem_rdata;
            pend2_d  = 1'b0;
          end else begin
            rdata1_d = mem_rdata;
            pend1_d  = 1'b0;
          end
          state_d = more ? ISSUE : RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any batch in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pend1_q  <= 1'b0;
      pend2_q  <= 1'b0;
      v1_q     <= 1'b0;
      we1_q    <= 1'b0;
      addr1_q  <= '0;
      wdata1_q <= '0;
      v2_q     <= 1'b0;
      we2_q    <= 1'b0;
      addr2_q  <= '0;
      wdata2_q <= '0;
      cnt_q    <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else begin
      state_q  <= state_d;
      pend1_q  <= pend1_d;
      pend2_q  <= pend2_d;
      v1_q     <= v1_d;
      we1_q    <= we1_d;
      addr1_q  <= addr1_d;
      wdata1_q <= wdata1_d;
      v2_q     <= v2_d;
      we2_q    <= we2_d;
      addr2_q  <= addr2_d;
      wdata2_q <= wdata2_d;
      cnt_q    <= cnt_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
    end
  end

  // Outputs decode from state so reset clears them without a clock edge.
  always_comb begin
    mem_en    = (state_q == ISSUE);
    mem_we    = mem_en & sel_we;
    mem_addr  = mem_en ? sel_addr : '0;
    mem_wdata = mem_en ? sel_wdata : '0;
    rvalid1   = (state_q == RESP) & v1_q & ~we1_q;
    rvalid2   = (state_q == RESP) & v2_q & ~we2_q;
    stall     = ((state_q == IDLE) & (req1_valid | req2_valid)) |
                (state_q == ISSUE) | (state_q == WAIT);
    rdata1    = rdata1_q;
    rdata2    = rdata2_q;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: one instance with MEM_LAT=1 and one with
// MEM_LAT=3, each with its own memory. A transaction-level model predicts every
// cycle's outputs; directed batches add literal expectations.
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] r1v, r1w, r2v, r2w;
  logic [7:0] r1a [2];
  logic [7:0] r1d [2];
  logic [7:0] r2a [2];
  logic [7:0] r2d [2];

  logic [1:0] m_en, m_we, rv1, rv2, stl;
  logic [7:0] m_addr [2];
  logic [7:0] m_wd [2];
  logic [7:0] m_rd [2];
  logic [7:0] rd1 [2];
  logic [7:0] rd2 [2];

  int n_tests = 0;
  int n_fail  = 0;

  dmem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1)) u_dut_l1 (
    .clk(clk), .reset(rst_n),
    .req1_valid(r1v[0]), .req1_we(r1w[0]), .req1_addr(r1a[0]), .req1_wdata(r1d[0]),
    .req2_valid(r2v[0]), .req2_we(r2w[0]), .req2_addr(r2a[0]), .req2_wdata(r2d[0]),
    .mem_en(m_en[0]), .mem_we(m_we[0]), .mem_addr(m_addr[0]), .mem_wdata(m_wd[0]),
    .mem_rdata(m_rd[0]), .rdata1(rd1[0]), .rdata2(rd2[0]),
    .rvalid1(rv1[0]), .rvalid2(rv2[0]), .stall(stl[0])
  );

  dmem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3)) u_dut_l3 (
    .clk(clk), .reset(rst_n),
    .req1_valid(r1v[1]), .req1_we(r1w[1]), .req1_addr(r1a[1]), .req1_wdata(r1d[1]),
    .req2_valid(r2v[1]), .req2_we(r2w[1]), .req2_addr(r2a[1]), .req2_wdata(r2d[1]),
    .mem_en(m_en[1]), .mem_we(m_we[1]), .mem_addr(m_addr[1]), .mem_wdata(m_wd[1]),
    .mem_rdata(m_rd[1]), .rdata1(rd1[1]), .rdata2(rd2[1]),
    .rvalid1(rv1[1]), .rvalid2(rv2[1]), .stall(stl[1])
  );

  // Memories: synchronous write, read data appears MEM_LAT cycles after mem_en.
  logic [7:0] mem0 [256] = '{default: 8'h00};
  logic [7:0] mem1 [256] = '{default: 8'h00};
  logic [7:0] p0, p1a, p1b, p1c;
  assign m_rd[0] = p0;
  assign m_rd[1] = p1c;

  always @(posedge clk) begin
    if (m_en[0] && m_we[0]) mem0[m_addr[0]] <= m_wd[0];
    if (m_en[1] && m_we[1]) mem1[m_addr[1]] <= m_wd[1];
    p0  <= mem0[m_addr[0]];
    p1a <= mem1[m_addr[1]];
    p1b <= p1a;
    p1c <= p1b;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic       stall;
    logic       en;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       rv1;
    logic       rv2;
    logic [7:0] rd1;
    logic [7:0] rd2;
  } exp_t;

  exp_t       q [2][$];
  logic [7:0] mmem [2][256] = '{default: '{default: 8'h00}};
  logic [7:0] held1 [2] = '{8'h00, 8'h00};
  logic [7:0] held2 [2] = '{8'h00, 8'h00};

  function automatic exp_t mk(input logic s, e, w, input logic [7:0] a, d,
                              input logic v1, v2, input logic [7:0] x1, x2);
    exp_t r;
    r = '{stall: s, en: e, we: w, addr: a, wdata: d, rv1: v1, rv2: v2, rd1: x1, rd2: x2};
    return r;
  endfunction

  // Expand a batch accepted this cycle into the expected outputs of the following cycles.
  task automatic build(input int i);
    int         lat;
    logic [7:0] c1v, c2v;
    lat = (i == 0) ? 1 : 3;
    c1v = held1[i];
    c2v = held2[i];
    if (r1v[i]) begin
      q[i].push_back(mk(1, 1, r1w[i], r1a[i], r1d[i], 0, 0, c1v, c2v));
      if (r1w[i]) mmem[i][r1a[i]] = r1d[i];
      else begin
        for (int k = 0; k < lat; k++) q[i].push_back(mk(1, 0, 0, 0, 0, 0, 0, c1v, c2v));
        c1v = mmem[i][r1a[i]];
      end
    end
    if (r2v[i]) begin
      q[i].push_back(mk(1, 1, r2w[i], r2a[i], r2d[i], 0, 0, c1v, c2v));
      if (r2w[i]) mmem[i][r2a[i]] = r2d[i];
      else begin
        for (int k = 0; k < lat; k++) q[i].push_back(mk(1, 0, 0, 0, 0, 0, 0, c1v, c2v));
        c2v = mmem[i][r2a[i]];
      end
    end
    q[i].push_back(mk(0, 0, 0, 0, 0, r1v[i] & ~r1w[i], r2v[i] & ~r2w[i], c1v, c2v));
    held1[i] = c1v;
    held2[i] = c2v;
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        q[i].delete();
        held1[i] = 8'h00;
        held2[i] = 8'h00;
        e = mk(r1v[i] | r2v[i], 0, 0, 0, 0, 0, 0, 0, 0);
      end else if (q[i].size() > 0) begin
        e = q[i].pop_front();
      end else begin
        e = mk(r1v[i] | r2v[i], 0, 0, 0, 0, 0, 0, held1[i], held2[i]);
        if (e.stall) build(i);
      end
      check($sformatf("cyc%0t_i%0d_stall", $time, i), stl[i], e.stall);
      check($sformatf("cyc%0t_i%0d_mem_en", $time, i), m_en[i], e.en);
      if (e.en) begin
        check($sformatf("cyc%0t_i%0d_mem_we", $time, i), m_we[i], e.we);
        check($sformatf("cyc%0t_i%0d_mem_addr", $time, i), m_addr[i], e.addr);
        check($sformatf("cyc%0t_i%0d_mem_wdata", $time, i), m_wd[i], e.wdata);
      end
      check($sformatf("cyc%0t_i%0d_rvalid1", $time, i), rv1[i], e.rv1);
      check($sformatf("cyc%0t_i%0d_rvalid2", $time, i), rv2[i], e.rv2);
      check($sformatf("cyc%0t_i%0d_rdata1", $time, i), rd1[i], e.rd1);
      check($sformatf("cyc%0t_i%0d_rdata2", $time, i), rd2[i], e.rd2);
    end
  end

  // ---------------- directed stimulus ----------------
  logic       tr_stall [32];
  logic       tr_en    [32];
  logic       tr_we    [32];
  logic       tr_rv1   [32];
  logic       tr_rv2   [32];
  logic [7:0] tr_addr  [32];
  logic [7:0] tr_wd    [32];
  logic [7:0] tr_rd1   [32];
  logic [7:0] tr_rd2   [32];
  int         resp_c;

  // Called just after a rising edge; c0 is the current cycle. Holds the requests
  // while stalled and returns just after the edge that leaves RESP.
  task automatic run_batch(input int i, input logic v1, w1, input logic [7:0] a1, d1,
                           input logic v2, w2, input logic [7:0] a2, d2);
    r1v[i] = v1; r1w[i] = w1; r1a[i] = a1; r1d[i] = d1;
    r2v[i] = v2; r2w[i] = w2; r2a[i] = a2; r2d[i] = d2;
    resp_c = -1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      tr_stall[c] = stl[i]; tr_en[c] = m_en[i]; tr_we[c] = m_we[i];
      tr_addr[c] = m_addr[i]; tr_wd[c] = m_wd[i];
      tr_rv1[c] = rv1[i]; tr_rv2[c] = rv2[i]; tr_rd1[c] = rd1[i]; tr_rd2[c] = rd2[i];
      if (c > 0 && !stl[i]) begin
        resp_c = c;
        break;
      end
      @(posedge clk); #1;
    end
    if (resp_c < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL batch_timeout: instance %0d got no RESP, required within 24 cycles", i);
    end
    @(posedge clk); #1;
    r1v[i] = 1'b0;
    r2v[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      r1v[i] = 0; r1w[i] = 0; r1a[i] = 0; r1d[i] = 0;
      r2v[i] = 0; r2w[i] = 0; r2a[i] = 0; r2d[i] = 0;
    end
    @(negedge clk);
    check("reset_stall0", stl[0], 0);
    check("reset_mem_en1", m_en[1], 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // MEM_LAT=1: single store 0x10 <= 0x5A
    run_batch(0, 1, 1, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00);
    check("wr1_resp_cycle", resp_c, 2);
    check("wr1_c1_en", tr_en[1], 1);
    check("wr1_c1_we", tr_we[1], 1);
    check("wr1_c1_addr", tr_addr[1], 8'h10);
    check("wr1_c1_wdata", tr_wd[1], 8'h5A);
    check("wr1_c2_rvalid1", tr_rv1[2], 0);

    // single load 0x10
    run_batch(0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    check("rd1_c0_stall", tr_stall[0], 1);
    check("rd1_c2_stall", tr_stall[2], 1);
    check("rd1_c1_addr", tr_addr[1], 8'h10);
    check("rd1_c2_en", tr_en[2], 0);
    check("rd1_resp_cycle", resp_c, 3);
    check("rd1_c3_rvalid1", tr_rv1[3], 1);
    check("rd1_c3_rdata1", tr_rd1[3], 8'h5A);
    check("rd1_c3_rvalid2", tr_rv2[3], 0);

    // lane-1 store then lane-2 load of the same address
    run_batch(0, 1, 1, 8'h20, 8'h33, 1, 0, 8'h20, 8'h00);
    check("raw_c1_we", tr_we[1], 1);
    check("raw_c1_addr", tr_addr[1], 8'h20);
    check("raw_c2_en", tr_en[2], 1);
    check("raw_c2_we", tr_we[2], 0);
    check("raw_resp_cycle", resp_c, 4);
    check("raw_c4_rvalid2", tr_rv2[4], 1);
    check("raw_c4_rdata2", tr_rd2[4], 8'h33);
    check("raw_c4_rvalid1", tr_rv1[4], 0);
    check("raw_c4_rdata1_kept", tr_rd1[4], 8'h5A);

    // two stores to one address, then back-to-back loads of it on both lanes
    run_batch(0, 1, 1, 8'h30, 8'h11, 1, 1, 8'h30, 8'h22);
    check("waw_resp_cycle", resp_c, 3);
    check("waw_c1_wdata", tr_wd[1], 8'h11);
    check("waw_c2_wdata", tr_wd[2], 8'h22);
    check("waw_c3_rvalid", {tr_rv1[3], tr_rv2[3]}, 2'b00);
    run_batch(0, 1, 0, 8'h30, 8'h00, 1, 0, 8'h30, 8'h00);
    check("rr_resp_cycle", resp_c, 5);
    check("rr_c3_en", tr_en[3], 1);
    check("rr_c5_rdata1", tr_rd1[5], 8'h22);
    check("rr_c5_rdata2", tr_rd2[5], 8'h22);
    check("rr_c5_rvalid", {tr_rv1[5], tr_rv2[5]}, 2'b11);
    run_batch(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00);
    check("l2_resp_cycle", resp_c, 3);
    check("l2_c3_rdata2", tr_rd2[3], 8'h5A);
    check("l2_c3_rdata1_kept", tr_rd1[3], 8'h22);

    // MEM_LAT=3: lane-2 store then lane-2 load of 0x05
    run_batch(1, 0, 0, 8'h00, 8'h00, 1, 1, 8'h05, 8'hC3);
    check("l3wr_resp_cycle", resp_c, 2);
    run_batch(1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h05, 8'h00);
    check("l3rd_c1_en", tr_en[1], 1);
    check("l3rd_c1_addr", tr_addr[1], 8'h05);
    check("l3rd_c3_en", tr_en[3], 0);
    check("l3rd_c4_stall", tr_stall[4], 1);
    check("l3rd_resp_cycle", resp_c, 5);
    check("l3rd_c5_rvalid2", tr_rv2[5], 1);
    check("l3rd_c5_rdata2", tr_rd2[5], 8'hC3);
    check("l3rd_c5_rvalid1", tr_rv1[5], 0);

    // asynchronous reset in the middle of a MEM_LAT=3 read
    r1v[1] = 1; r1w[1] = 0; r1a[1] = 8'h05;
    @(posedge clk); #1;
    @(posedge clk); #2;
    check("arst_pre_stall", stl[1], 1);
    rst_n = 1'b0;
    r1v[1] = 0;
    #1;
    check("arst_mem_en", m_en[1], 0);
    check("arst_stall", stl[1], 0);
    check("arst_rvalid", {rv1[1], rv2[1]}, 2'b00);
    check("arst_rdata2", rd2[1], 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_idle%0d_stall", k), {stl[1], stl[0]}, 2'b00);
      check($sformatf("post_rst_idle%0d_mem_en", k), {m_en[1], m_en[0]}, 2'b00);
    end
    @(posedge clk); #1;

    // memory survives the arbiter reset
    run_batch(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h30, 8'h00);
    check("post_rst_rdata2", tr_rd2[3], 8'h22);
    check("post_rst_rdata1", tr_rd1[3], 8'h00);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Arbitrates the two pipeline lanes' EX/MEM memory requests onto one single-ported data memory bank.
- Requests are served strictly in program order (lane 1 older than lane 2).
- The pipeline is stalled until the whole batch completes.
- Sits between the EX/MEM register outputs and the data memory, and replaces the per-lane direct memory hookup.

Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 8, data width
- MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..15

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req1_valid  in  1  lane-1 memory op present (memread or memwrite)
- req1_we  in  1  lane-1 write (1) / read (0)
- req1_addr  in  ADDR_W  lane-1 address
- req1_wdata  in  DATA_W  lane-1 store data
- req2_valid, req2_we, req2_addr, req2_wdata  in  1/1/ADDR_W/DATA_W  same fields for lane 2
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
- rdata1, rdata2  out  DATA_W  per-lane load result
- rvalid1, rvalid2  out  1  per-lane load-complete pulse
- stall  out  1  holds PC, IF/ID, ID/EX and EX/MEM

Behaviour:
- One clock, clk. reset is asynchronous and active-low.
- reset=0 acts immediately:
  - state=IDLE; pending bits, counter and latched requests cleared.
  - mem_en, mem_we, rvalid1, rvalid2 = 0; mem_addr, mem_wdata, rdata1, rdata2 = 0.
  - stall follows its combinational definition.
  - Applies mid-batch as well; the aborted batch is discarded.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req1_valid or req2_valid, latch both lanes' fields and set pend1=req1_valid, pend2=req2_valid, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - Select the lane: pend1 ? lane 1 : lane 2.
  - Drive mem_en=1, mem_we, mem_addr and mem_wdata from the latched fields of that lane.
  - Write: clear that lane's pend bit. If the other pend bit is still set, go to ISSUE again; else go to RESP.
  - Read: load cnt=MEM_LAT and go to WAIT.
- WAIT:
  - Decrement cnt each cycle.
  - On the cycle cnt==1, capture mem_rdata into the selected lane's rdata register and clear its pend bit.
  - Then go to ISSUE if the other lane is still pending, else to RESP.
  - WAIT lasts exactly MEM_LAT cycles.
- RESP (one cycle):
  - rvalid1 = lane-1 was a read in this batch; rvalid2 = lane-2 was a read in this batch.
  - Go to IDLE.
- stall = (state==IDLE & (req1_valid|req2_valid)) | state==ISSUE | state==WAIT.
  - stall=0 in RESP so the pipeline advances on that edge.
- Requests arriving while state!=IDLE are ignored; the pipeline holds them stable under stall.
- rdataN holds its value until overwritten by a later load on the same lane.
- rvalidN is 0 outside RESP.
- Ordering:
  - Lane 1 always completes before lane 2.
  - Lane-1 store followed by lane-2 load to the same address returns the stored value.
  - Two stores to the same address leave lane-2's data in memory.
- Latency, single read: 2+MEM_LAT cycles of stall, RESP at detect cycle + 1 + MEM_LAT + 1.
- Latency, single write: 2 cycles of stall, RESP at detect+2.
- No-request cycles: stall=0, mem_en=0, zero overhead.

Test Plan:
- MEM_LAT=1, lane-1 read 0x10, mem[0x10]=0x5A:
  - stall=1 in c0–c2; mem_en=1, addr=0x10 in c1.
  - c3: rvalid1=1, rdata1=0x5A, stall=0, rvalid2=0.
- Lane-1 write 0x20<=0x33 with lane-2 read 0x20, MEM_LAT=1:
  - c1: mem_en, we=1, addr 0x20. c2: mem_en, we=0.
  - c4: rvalid2=1, rdata2=0x33, rvalid1=0.
- Both lanes write 0x30 (0x11, then 0x22) -> two consecutive write strobes, lane 1 first; mem[0x30]=0x22; RESP at c3 with no rvalid.
- MEM_LAT=3, lane-2-only read 0x05=0xC3 -> mem_en at c1, WAIT c2–c4, c5: rvalid2=1, rdata2=0xC3.
- reset driven low during WAIT -> mem_en, rvalid and state clear in the same cycle with no clock edge. After release with no requests: stall=0 and mem_en=0 indefinitely.
- Back-to-back batches: new requests presented in the RESP cycle's successor -> accepted in IDLE; no request lost or issued twice; prior rdata retained until overwritten.
